// File: rtl/sasanqua_cop_pkg.sv
// Shared coprocessor writeback types and widths, used by the coprocessor exec
// outputs and the writeback arbiter.
package sasanqua_cop_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_IDX_W  = 5;
   localparam int unsigned EXC_CODE_W = 4;

   // One coprocessor result as seen by the core commit logic
   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic                  reg_w_en;
      logic [REG_IDX_W-1:0]  reg_w_rd;
      logic [XLEN-1:0]       reg_w_data;
      logic                  exc_en;
      logic [EXC_CODE_W-1:0] exc_code;
   } cop_wb_t;

   localparam int unsigned COP_WB_W = $bits(cop_wb_t);

   // Index width for n sources, never narrower than one bit
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sasanqua_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr+1 and wraps; the
// pointer register lives in the parent.
module sasanqua_rr_arbiter
   import sasanqua_cop_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = IDX_W'((32'(ptr) + k) % N);
         if (en && !grant_valid && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sasanqua_cop_wb_arbiter.sv
// Shares the core writeback port between COP_NUMS coprocessor result streams
// via per-source skid buffers, a round-robin arbiter and a registered output.
// Optional: SASANQUA_COP_WB_EXC_PRIO_EN gives pending exceptions priority.
module sasanqua_cop_wb_arbiter
   import sasanqua_cop_pkg::*;
#(
   parameter int unsigned COP_NUMS = 2,
   parameter int unsigned SRC_W    = idx_w(COP_NUMS)
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           FLUSH,
   input  logic                           STALL,
   input  logic [COP_NUMS-1:0]            I_VALID,
   output logic [COP_NUMS-1:0]            I_READY,
   input  logic [XLEN*COP_NUMS-1:0]       I_PC,
   input  logic [COP_NUMS-1:0]            I_REG_W_EN,
   input  logic [REG_IDX_W*COP_NUMS-1:0]  I_REG_W_RD,
   input  logic [XLEN*COP_NUMS-1:0]       I_REG_W_DATA,
   input  logic [COP_NUMS-1:0]            I_EXC_EN,
   input  logic [EXC_CODE_W*COP_NUMS-1:0] I_EXC_CODE,
   output logic                           O_VALID,
   output logic [SRC_W-1:0]               O_SRC,
   output logic [XLEN-1:0]                O_PC,
   output logic                           O_REG_W_EN,
   output logic [REG_IDX_W-1:0]           O_REG_W_RD,
   output logic [XLEN-1:0]                O_REG_W_DATA,
   output logic                           O_EXC_EN,
   output logic [EXC_CODE_W-1:0]          O_EXC_CODE
);

   cop_wb_t             in_wb [COP_NUMS];
   cop_wb_t             buf_q [COP_NUMS];
   logic [COP_NUMS-1:0] full_q;
   logic [SRC_W-1:0]    ptr_q;

   logic [COP_NUMS-1:0] arb_req;
   logic [COP_NUMS-1:0] grant;
   logic [SRC_W-1:0]    grant_idx;
   logic                grant_valid;
   logic                arb_en;
   logic [COP_NUMS-1:0] ready_c;
   logic [COP_NUMS-1:0] xfer;
   cop_wb_t             win;

   cop_wb_t             out_q;
   logic                out_valid_q;
   logic [SRC_W-1:0]    out_src_q;

   for (genvar g = 0; g < COP_NUMS; g++) begin : g_unpack
      assign in_wb[g] = {I_PC[g*XLEN +: XLEN],
                         I_REG_W_EN[g],
                         I_REG_W_RD[g*REG_IDX_W +: REG_IDX_W],
                         I_REG_W_DATA[g*XLEN +: XLEN],
                         I_EXC_EN[g],
                         I_EXC_CODE[g*EXC_CODE_W +: EXC_CODE_W]};
   end

   assign arb_en = ~STALL & ~FLUSH;

`ifdef SASANQUA_COP_WB_EXC_PRIO_EN
   // Pending exceptions shadow every normal entry while any is buffered
   logic [COP_NUMS-1:0] exc_pend;

   for (genvar g = 0; g < COP_NUMS; g++) begin : g_exc
      assign exc_pend[g] = full_q[g] & buf_q[g].exc_en;
   end

   assign arb_req = (|exc_pend) ? exc_pend : full_q;
`else
   assign arb_req = full_q;
`endif

   sasanqua_rr_arbiter #(
      .N     (COP_NUMS),
      .IDX_W (SRC_W)
   ) u_rr_arbiter (
      .req         (arb_req),
      .ptr         (ptr_q),
      .en          (arb_en),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Ready depends only on buffer state and core controls, never on I_VALID
   assign ready_c = {COP_NUMS{RST & ~FLUSH}} &
                    (~full_q | (grant & {COP_NUMS{~STALL}}));
   assign I_READY = ready_c;
   assign xfer    = I_VALID & ready_c;

   always_comb begin
      win = '0;
      for (int unsigned i = 0; i < COP_NUMS; i++) begin
         if (grant[i]) begin
            win = buf_q[i];
         end
      end
   end

   // Skid buffers: refill wins over drain so a granted slot can be reloaded
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         full_q <= '0;
         for (int unsigned i = 0; i < COP_NUMS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < COP_NUMS; i++) begin
            if (FLUSH) begin
               full_q[i] <= 1'b0;
            end else if (xfer[i]) begin
               full_q[i] <= 1'b1;
               buf_q[i]  <= in_wb[i];
            end else if (grant[i]) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr_q <= SRC_W'(COP_NUMS - 1);
      end else if (grant_valid) begin
         ptr_q <= grant_idx;
      end
   end

   // Output stage: flush clears, stall holds, otherwise load winner or zero
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_valid_q <= 1'b0;
         out_src_q   <= '0;
         out_q       <= '0;
      end else if (FLUSH) begin
         out_valid_q <= 1'b0;
         out_src_q   <= '0;
         out_q       <= '0;
      end else if (!STALL) begin
         if (grant_valid) begin
            out_valid_q <= 1'b1;
            out_src_q   <= grant_idx;
            out_q       <= win;
         end else begin
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_q       <= '0;
         end
      end
   end

   assign O_VALID      = out_valid_q;
   assign O_SRC        = out_src_q;
   assign O_PC         = out_q.pc;
   assign O_REG_W_EN   = out_q.reg_w_en;
   assign O_REG_W_RD   = out_q.reg_w_rd;
   assign O_REG_W_DATA = out_q.reg_w_data;
   assign O_EXC_EN     = out_q.exc_en;
   assign O_EXC_CODE   = out_q.exc_code;

endmodule

// File: tb/tb_sasanqua_cop_wb_arbiter.sv
// Directed bench for sasanqua_cop_wb_arbiter with two sources; follows
// SASANQUA_COP_WB_EXC_PRIO_EN for the exception-priority expectation.
module tb_sasanqua_cop_wb_arbiter;

   localparam int unsigned N = 2;

   logic           CLK;
   logic           RST;
   logic           FLUSH;
   logic           STALL;
   logic [N-1:0]   I_VALID;
   logic [N-1:0]   I_READY;
   logic [32*N-1:0] I_PC;
   logic [N-1:0]   I_REG_W_EN;
   logic [5*N-1:0] I_REG_W_RD;
   logic [32*N-1:0] I_REG_W_DATA;
   logic [N-1:0]   I_EXC_EN;
   logic [4*N-1:0] I_EXC_CODE;
   logic           O_VALID;
   logic [0:0]     O_SRC;
   logic [31:0]    O_PC;
   logic           O_REG_W_EN;
   logic [4:0]     O_REG_W_RD;
   logic [31:0]    O_REG_W_DATA;
   logic           O_EXC_EN;
   logic [3:0]     O_EXC_CODE;

   logic [76:0]    obs;
   logic [76:0]    expv;
   int             checks   = 0;
   int             failures = 0;

   assign obs = {O_VALID, O_SRC, O_PC, O_REG_W_EN, O_REG_W_RD, O_REG_W_DATA,
                 O_EXC_EN, O_EXC_CODE};

   sasanqua_cop_wb_arbiter #(.COP_NUMS(2)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .FLUSH        (FLUSH),
      .STALL        (STALL),
      .I_VALID      (I_VALID),
      .I_READY      (I_READY),
      .I_PC         (I_PC),
      .I_REG_W_EN   (I_REG_W_EN),
      .I_REG_W_RD   (I_REG_W_RD),
      .I_REG_W_DATA (I_REG_W_DATA),
      .I_EXC_EN     (I_EXC_EN),
      .I_EXC_CODE   (I_EXC_CODE),
      .O_VALID      (O_VALID),
      .O_SRC        (O_SRC),
      .O_PC         (O_PC),
      .O_REG_W_EN   (O_REG_W_EN),
      .O_REG_W_RD   (O_REG_W_RD),
      .O_REG_W_DATA (O_REG_W_DATA),
      .O_EXC_EN     (O_EXC_EN),
      .O_EXC_CODE   (O_EXC_CODE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      I_VALID      = '0;
      I_PC         = '0;
      I_REG_W_EN   = '0;
      I_REG_W_RD   = '0;
      I_REG_W_DATA = '0;
      I_EXC_EN     = '0;
      I_EXC_CODE   = '0;
   endtask

   task automatic set_src(input int i, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] data, input logic exc, input logic [3:0] code);
      I_VALID[i]              = 1'b1;
      I_PC[32*i +: 32]        = pc;
      I_REG_W_EN[i]           = 1'b1;
      I_REG_W_RD[5*i +: 5]    = rd;
      I_REG_W_DATA[32*i +: 32] = data;
      I_EXC_EN[i]             = exc;
      I_EXC_CODE[4*i +: 4]    = code;
   endtask

   task automatic do_reset();
      clear_inputs();
      FLUSH = 1'b0;
      STALL = 1'b0;
      RST   = 1'b0;
      tick();
      tick();
      RST = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      FLUSH = 1'b0;
      STALL = 1'b0;
      RST   = 1'b0;
      set_src(0, 32'h100, 5'd1, 32'h11111111, 1'b0, 4'h0);
      set_src(1, 32'h200, 5'd2, 32'h22222222, 1'b0, 4'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (I_READY !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready c=%0d: got %b expected 00", c, I_READY);
         end
         checks++;
         if (obs !== 77'd0) begin
            failures++;
            $display("FAIL reset_outputs c=%0d: got %h expected 0", c, obs);
         end
      end
      RST = 1'b1;
      #1;
      checks++;
      if (I_READY !== 2'b11) begin
         failures++;
         $display("FAIL release_ready: got %b expected 11", I_READY);
      end
      tick();
      checks++;
      if (I_READY !== 2'b01) begin
         failures++;
         $display("FAIL first_grant_ready: got %b expected 01", I_READY);
      end
      clear_inputs();
      tick();
      expv = {1'b1, 1'b0, 32'h100, 1'b1, 5'd1, 32'h11111111, 1'b0, 4'h0};
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL reset_first_out: got %h expected %h", obs, expv);
      end
      tick();
      expv = {1'b1, 1'b1, 32'h200, 1'b1, 5'd2, 32'h22222222, 1'b0, 4'h0};
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL reset_second_out: got %h expected %h", obs, expv);
      end
      tick();
      checks++;
      if (obs !== 77'd0) begin
         failures++;
         $display("FAIL reset_idle_out: got %h expected 0", obs);
      end
   endtask

   task automatic test_contention();
      int cnt0 = 0;
      int cnt1 = 0;
      int k;
      int j;
      logic [1:0] acc;
      do_reset();
      for (int c = 0; c < 14; c++) begin
         if (c < 10) begin
            set_src(0, 32'h1000 + 32'(4*cnt0), 5'd1, 32'h11110000 + 32'(cnt0), 1'b0, 4'h0);
            set_src(1, 32'h2000 + 32'(4*cnt1), 5'd2, 32'h22220000 + 32'(cnt1), 1'b0, 4'h0);
         end else begin
            clear_inputs();
         end
         #1;
         if (c < 2 || c > 12) begin
            expv = '0;
         end else begin
            k = c - 2;
            j = k / 2;
            if (k % 2 == 0)
               expv = {1'b1, 1'b0, 32'h1000 + 32'(4*j), 1'b1, 5'd1, 32'h11110000 + 32'(j), 1'b0, 4'h0};
            else
               expv = {1'b1, 1'b1, 32'h2000 + 32'(4*j), 1'b1, 5'd2, 32'h22220000 + 32'(j), 1'b0, 4'h0};
         end
         checks++;
         if (obs !== expv) begin
            failures++;
            $display("FAIL contention_out c=%0d: got %h expected %h", c, obs, expv);
         end
         acc = I_VALID & I_READY;
         tick();
         if (acc[0]) cnt0++;
         if (acc[1]) cnt1++;
      end
      checks++;
      if (cnt0 != 6 || cnt1 != 5) begin
         failures++;
         $display("FAIL contention_accepts: got %0d/%0d expected 6/5", cnt0, cnt1);
      end
   endtask

   task automatic test_stall();
      logic [76:0] held;
      do_reset();
      set_src(0, 32'h80000010, 5'd3, 32'hAAAA0001, 1'b0, 4'h0);
      #1;
      tick();
      set_src(0, 32'h80000014, 5'd3, 32'hAAAA0002, 1'b0, 4'h0);
      set_src(1, 32'h80000020, 5'd4, 32'hBBBB0001, 1'b0, 4'h0);
      #1;
      checks++;
      if (I_READY !== 2'b11) begin
         failures++;
         $display("FAIL stall_prefill_ready: got %b expected 11", I_READY);
      end
      tick();
      held = {1'b1, 1'b0, 32'h80000010, 1'b1, 5'd3, 32'hAAAA0001, 1'b0, 4'h0};
      STALL = 1'b1;
      set_src(0, 32'h80000018, 5'd3, 32'hAAAA0003, 1'b0, 4'h0);
      set_src(1, 32'h80000024, 5'd4, 32'hBBBB0002, 1'b0, 4'h0);
      for (int s = 0; s < 4; s++) begin
         #1;
         checks++;
         if (obs !== held) begin
            failures++;
            $display("FAIL stall_hold s=%0d: got %h expected %h", s, obs, held);
         end
         checks++;
         if (I_READY !== 2'b00) begin
            failures++;
            $display("FAIL stall_ready s=%0d: got %b expected 00", s, I_READY);
         end
         tick();
      end
      STALL = 1'b0;
      clear_inputs();
      #1;
      checks++;
      if (obs !== held) begin
         failures++;
         $display("FAIL stall_last_hold: got %h expected %h", obs, held);
      end
      tick();
      expv = {1'b1, 1'b1, 32'h80000020, 1'b1, 5'd4, 32'hBBBB0001, 1'b0, 4'h0};
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL stall_release_first: got %h expected %h", obs, expv);
      end
      tick();
      expv = {1'b1, 1'b0, 32'h80000014, 1'b1, 5'd3, 32'hAAAA0002, 1'b0, 4'h0};
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL stall_release_second: got %h expected %h", obs, expv);
      end
      tick();
      checks++;
      if (obs !== 77'd0) begin
         failures++;
         $display("FAIL stall_drained: got %h expected 0", obs);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_src(0, 32'h300, 5'd5, 32'h33330000, 1'b0, 4'h0);
      set_src(1, 32'h400, 5'd6, 32'h44440000, 1'b0, 4'h0);
      #1;
      tick();
      clear_inputs();
      set_src(0, 32'h304, 5'd5, 32'h33330001, 1'b0, 4'h0);
      #1;
      checks++;
      if (I_READY !== 2'b01) begin
         failures++;
         $display("FAIL flush_prefill_ready: got %b expected 01", I_READY);
      end
      tick();
      clear_inputs();
      FLUSH = 1'b1;
      set_src(1, 32'h4F0, 5'd6, 32'h4444FFFF, 1'b0, 4'h0);
      #1;
      expv = {1'b1, 1'b0, 32'h300, 1'b1, 5'd5, 32'h33330000, 1'b0, 4'h0};
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL flush_pre_out: got %h expected %h", obs, expv);
      end
      checks++;
      if (I_READY !== 2'b00) begin
         failures++;
         $display("FAIL flush_ready: got %b expected 00", I_READY);
      end
      tick();
      FLUSH = 1'b0;
      clear_inputs();
      #1;
      checks++;
      if (obs !== 77'd0) begin
         failures++;
         $display("FAIL flush_out_cleared: got %h expected 0", obs);
      end
      checks++;
      if (I_READY !== 2'b11) begin
         failures++;
         $display("FAIL flush_bufs_empty: got %b expected 11", I_READY);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (obs !== 77'd0) begin
            failures++;
            $display("FAIL flush_no_leak c=%0d: got %h expected 0", c, obs);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c < 11; c++) begin
         clear_inputs();
         if (c < 8)
            set_src(0, 32'(4*c), 5'd7, 32'h70000000 + 32'(c), 1'b0, 4'h0);
         #1;
         if (c < 8) begin
            checks++;
            if (I_READY[0] !== 1'b1) begin
               failures++;
               $display("FAIL b2b_ready c=%0d: got %b expected 1", c, I_READY[0]);
            end
         end
         if (c >= 2 && c <= 9)
            expv = {1'b1, 1'b0, 32'(4*(c-2)), 1'b1, 5'd7, 32'h70000000 + 32'(c-2), 1'b0, 4'h0};
         else
            expv = '0;
         checks++;
         if (obs !== expv) begin
            failures++;
            $display("FAIL b2b_out c=%0d: got %h expected %h", c, obs, expv);
         end
         tick();
      end
   endtask

   task automatic test_exc_prio();
      logic [76:0] out_normal;
      logic [76:0] out_exc;
      out_normal = {1'b1, 1'b0, 32'h500, 1'b1, 5'd8, 32'h55550000, 1'b0, 4'h0};
      out_exc    = {1'b1, 1'b1, 32'h600, 1'b1, 5'd9, 32'h66660000, 1'b1, 4'd2};
      do_reset();
      set_src(0, 32'h500, 5'd8, 32'h55550000, 1'b0, 4'h0);
      set_src(1, 32'h600, 5'd9, 32'h66660000, 1'b1, 4'd2);
      #1;
      tick();
      clear_inputs();
      tick();
`ifdef SASANQUA_COP_WB_EXC_PRIO_EN
      expv = out_exc;
`else
      expv = out_normal;
`endif
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL exc_prio_first: got %h expected %h", obs, expv);
      end
      tick();
`ifdef SASANQUA_COP_WB_EXC_PRIO_EN
      expv = out_normal;
`else
      expv = out_exc;
`endif
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL exc_prio_second: got %h expected %h", obs, expv);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_stall();
      test_flush();
      test_back_to_back();
      test_exc_prio();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
